// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Fetch stage for the single-cycle RISC-V core. Holds the PC,
//             fetches from instruction memory over a req/ack handshake,
//             presents the word to the decoder and advances the PC by either
//             +4 or the sign-extended branch offset when the core consumes it.
//  Options  : FETCH_MISALIGN_TRAP_EN - trap on a misaligned next PC (sticky
//             FAULT state) instead of silently clearing the low PC bits.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            pc_src,
    input  logic [XLEN-1:0] imm_ext,
    output logic            fetch_fault
);

    // addi x0, x0, 0 - harmless word shown to the decoder out of reset
    localparam logic [XLEN-1:0] c_NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_pcTarget;
    logic [XLEN-1:0] w_nextPc;
    logic [XLEN-1:0] w_pcLoad;
    logic            w_consume;
    logic            w_fetchDone;

    // Both candidate PCs wrap modulo 2^XLEN; no overflow is reported
    assign w_pcPlus4  = r_pc + XLEN'(4);
    assign w_pcTarget = r_pc + imm_ext;
    assign w_nextPc   = pc_src ? w_pcTarget : w_pcPlus4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misaligned;
    // The offending PC is kept as-is so the trap handler can see it
    assign w_misaligned = (w_nextPc[1:0] != 2'b00);
    assign w_pcLoad     = w_nextPc;
`else
    // Without the trap, a misaligned target is silently word-aligned
    assign w_pcLoad     = w_nextPc & ~XLEN'(3);
`endif

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pcPlus4;
    assign instr     = r_instr;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= START;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // PC and instruction latch; only updated on a completed fetch or a consume
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_instr <= c_NOP;
        end else begin
            if (w_fetchDone) begin
                r_instr <= imem_rdata;
            end
            if (w_consume) begin
                r_pc <= w_pcLoad;
            end
        end
    end

    // Next-state and handshake outputs decoded from the current state
    always_comb begin
        w_stateNext = r_state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        w_consume   = 1'b0;
        w_fetchDone = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault = 1'b0;
`endif
        case (r_state)
            START: begin
                w_stateNext = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_fetchDone = 1'b1;
                    w_stateNext = VALID;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    w_consume = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    w_stateNext = w_misaligned ? FAULT : FETCH;
`else
                    w_stateNext = FETCH;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: begin
                // Sticky until reset: no requests, nothing to execute
                fetch_fault = 1'b1;
            end
`endif
            default: begin
                w_stateNext = START;
            end
        endcase
    end

`ifndef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit (default or
//             FETCH_MISALIGN_TRAP_EN build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic        fetch_fault;

    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: architectural PC, last delivered word, trap flag
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic        mFault;

    typedef struct {
        logic [31:0] startPc;
        logic        src;
        logic [31:0] imm;
        logic [31:0] expAddr;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Reset and check the restored state; ends in the first FETCH cycle
    task automatic doReset();
        rst = 1'b1;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 32'h0000_0013);
        checkBit("rst_valid", instr_valid, 1'b0);
        checkBit("rst_req", imem_req, 1'b0);
        checkBit("rst_fault", fetch_fault, 1'b0);
        rst = 1'b0;
        checkBit("start_no_req", imem_req, 1'b0);
        tick();
        checkBit("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, RESET_PC);
        mPc = RESET_PC;
        mInstr = 32'h0000_0013;
        mFault = 1'b0;
    endtask

    // Complete one fetch with 'lat' no-ack cycles; ends in VALID
    task automatic fetchAt(input int lat);
        int waited = 0;
        while (!imem_req && waited < 8) begin
            tick();
            waited++;
        end
        checkBit("req_seen", imem_req, 1'b1);
        check("fetch_addr", imem_addr, mPc);
        for (int i = 0; i < lat; i++) begin
            imem_ack = 1'b0;
            instr_ready = 1'($urandom_range(0, 1));
            tick();
            checkBit("req_held", imem_req, 1'b1);
            check("addr_held", imem_addr, mPc);
            checkBit("wait_valid", instr_valid, 1'b0);
        end
        instr_ready = 1'b0;
        imem_rdata = memWord(imem_addr);
        mInstr = memWord(mPc);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        checkBit("valid", instr_valid, 1'b1);
        check("instr", instr, mInstr);
        check("pc", pc, mPc);
        check("pc_plus4", pc_plus4, mPc + 32'd4);
        checkBit("valid_no_req", imem_req, 1'b0);
    endtask

    // Stall 'delay' cycles in VALID (with stray acks), then consume
    task automatic consume(input logic src, input logic [31:0] imm, input int delay);
        logic [31:0] nxt;
        for (int i = 0; i < delay; i++) begin
            instr_ready = 1'b0;
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            pc_src = 1'($urandom_range(0, 1));
            imm_ext = $urandom;
            tick();
            checkBit("stall_valid", instr_valid, 1'b1);
            checkBit("stall_no_req", imem_req, 1'b0);
            check("stall_instr", instr, mInstr);
            check("stall_pc", pc, mPc);
        end
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        pc_src = src;
        imm_ext = imm;
        tick();
        instr_ready = 1'b0;
        pc_src = 1'($urandom_range(0, 1));
        imm_ext = $urandom;
        nxt = src ? (mPc + imm) : (mPc + 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
        if (nxt % 4 != 0) begin
            mFault = 1'b1;
            mPc = nxt;
        end else begin
            mPc = nxt;
        end
`else
        mPc = nxt - (nxt % 4);
`endif
        checkBit("fault_flag", fetch_fault, mFault);
        check("next_pc", pc, mPc);
        checkBit("after_valid", instr_valid, 1'b0);
        checkBit("after_req", imem_req, !mFault);
    endtask

    // From VALID, branch to 'target' and fetch it; ends in VALID
    task automatic gotoPc(input logic [31:0] target);
        consume(1'b1, target - mPc, 0);
        fetchAt(0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [31:0] imm;
        logic src;

        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        pc_src = 1'b0;
        imm_ext = 32'h0;
        mPc = RESET_PC;
        mInstr = 32'h13;
        mFault = 1'b0;

        // Zero-wait memory, always-ready core: one request every 2 cycles
        doReset();
        for (int i = 0; i < 3; i++) begin
            t0 = cyc;
            check("seq_addr", imem_addr, 32'(i * 4));
            fetchAt(0);
            consume(1'b0, 32'h0, 0);
            check("two_cycle_rate", 32'(cyc - t0), 32'd2);
        end

        // 3 wait cycles at pc=0x10
        fetchAt(0);
        consume(1'b0, 32'h0, 0);
        check("lat_addr", imem_addr, 32'h10);
        fetchAt(3);

        // 5 cycles of back-pressure with stray acks
        consume(1'b0, 32'h0, 5);
        fetchAt(1);

        // Branch / wrap vectors
        vecs.push_back('{32'h0000_0020, 1'b1, 32'hFFFF_FFF8, 32'h0000_0018});
        vecs.push_back('{32'h0000_0020, 1'b0, 32'h1234_5678, 32'h0000_0024});
        vecs.push_back('{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{32'h0000_0100, 1'b1, 32'h7FFF_FF00, 32'h8000_0000});
        vecs.push_back('{32'h8000_0000, 1'b1, 32'h8000_0000, 32'h0000_0000});
`ifndef FETCH_MISALIGN_TRAP_EN
        vecs.push_back('{32'h0000_0040, 1'b1, 32'h0000_0002, 32'h0000_0040});
        vecs.push_back('{32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 32'h0000_003C});
`endif
        foreach (vecs[k]) begin
            gotoPc(vecs[k].startPc);
            check("vec_start", pc, vecs[k].startPc);
            consume(vecs[k].src, vecs[k].imm, 0);
            check("vec_addr", imem_addr, vecs[k].expAddr);
            fetchAt(0);
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned target traps and stays trapped
        gotoPc(32'h0000_0040);
        consume(1'b1, 32'h0000_0002, 0);
        check("trap_pc", pc, 32'h0000_0042);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            tick();
            checkBit("trap_sticky", fetch_fault, 1'b1);
            checkBit("trap_no_req", imem_req, 1'b0);
            checkBit("trap_no_valid", instr_valid, 1'b0);
        end
        doReset();
        fetchAt(0);
`endif

        // Reset mid-FETCH with an ack in the same cycle
        gotoPc(32'h0000_0080);
        consume(1'b0, 32'h0, 0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("midfetch_rst_instr", instr, 32'h0000_0013);
        check("midfetch_rst_pc", pc, RESET_PC);
        doReset();

        // Reset during a consume cycle
        fetchAt(2);
        instr_ready = 1'b1;
        pc_src = 1'b1;
        imm_ext = 32'h0000_0400;
        rst = 1'b1;
        tick();
        check("consume_rst_pc", pc, RESET_PC);
        doReset();

        // Randomized run against the model
        for (int n = 0; n < 150; n++) begin
            fetchAt($urandom_range(0, 3));
            src = 1'($urandom_range(0, 1));
            imm = ($urandom_range(0, 64) << 2) - 32'd128;
`ifndef FETCH_MISALIGN_TRAP_EN
            if ($urandom_range(0, 7) == 0) imm = imm + 32'($urandom_range(1, 3));
`endif
            consume(src, imm, $urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) doReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
